// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one main-memory port between N_REQ cache controllers.
// Each request is latched into a per-requester pending slot. Slots are granted
// round-robin, one memory transaction at a time, and the completion goes back
// only to the owning requester.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to add a WAIT-cycle limit of
// TIMEOUT_CYC and the sticky err_timeout output.
module mem_port_arbiter #(
  parameter int N_REQ       = 2,
  parameter int AW          = 32,
  parameter int DW          = 128,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_rw,
  input  logic [N_REQ*AW-1:0]      req_addr,
  input  logic [N_REQ*DW-1:0]      req_data,
  output logic [N_REQ-1:0]         rsp_ready,
  output logic [DW-1:0]            rsp_data,
  output logic                     mem_valid,
  output logic                     mem_rw,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic                     mem_ready,
  input  logic [DW-1:0]            mem_rdata,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     err_overflow
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic                     err_timeout
`endif
);

  localparam int          OW = $clog2(N_REQ);
  localparam int unsigned NR = N_REQ;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state, state_nxt;
  logic [N_REQ-1:0]  pending, valid_q, capture, dup, done_mask;
  logic              slot_rw   [N_REQ];
  logic [AW-1:0]     slot_addr [N_REQ];
  logic [DW-1:0]     slot_data [N_REQ];
  logic [OW-1:0]     rr_ptr, pick;
  logic              any_pending, done, timed_out;

  assign busy      = (state != IDLE);
  assign mem_valid = (state == ISSUE);
  assign done      = (state == WAIT) && (mem_ready || timed_out);
  assign done_mask = done ? (N_REQ'(1) << owner) : '0;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wait_cnt;

  // The last allowed WAIT cycle is the TIMEOUT_CYC-th one after ISSUE.
  assign timed_out = (state == WAIT) && !mem_ready && (wait_cnt == CW'(TIMEOUT_CYC - 1));

  // Watchdog counter: cleared in ISSUE, counts WAIT cycles; sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == ISSUE)
        wait_cnt <= '0;
      else if (state == WAIT)
        wait_cnt <= wait_cnt + CW'(1);
      if (timed_out)
        err_timeout <= 1'b1;
    end
  end
`else
  // Watchdog disabled: WAIT lasts until mem_ready. TIMEOUT_CYC is only kept so
  // both builds accept the same parameter list.
  assign timed_out = (TIMEOUT_CYC < 0) && 1'b0;
`endif

  // Round-robin pick: the first pending slot at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned   idx;
    logic [OW-1:0] cand;
    idx         = 0;
    cand        = '0;
    pick        = '0;
    any_pending = 1'b0;
    // Scan from the farthest candidate back to rr_ptr so the nearest one wins.
    for (int unsigned k = 0; k < NR; k++) begin
      idx  = (32'(rr_ptr) + NR - 1 - k) % NR;
      cand = OW'(idx);
      if (pending[cand]) begin
        pick        = cand;
        any_pending = 1'b1;
      end
    end
  end

  // Slot capture and overflow detection per requester.
  always_comb begin
    capture = '0;
    dup     = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      // A slot being completed this cycle counts as empty, so a new request wins.
      if (req_valid[i] && (!pending[i] || done_mask[i]))
        capture[i] = 1'b1;
      else if (req_valid[i] && !valid_q[i] && !(busy && owner == OW'(i)))
        dup[i] = 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_pending) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Pending flags, grant, memory request fields, response and error flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending      <= '0;
      valid_q      <= '0;
      rr_ptr       <= '0;
      owner        <= '0;
      rsp_ready    <= '0;
      rsp_data     <= '0;
      mem_rw       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      err_overflow <= 1'b0;
    end else begin
      valid_q   <= req_valid;
      pending   <= (pending & ~done_mask) | capture;
      rsp_ready <= done_mask;
      if (done) begin
        rsp_data <= timed_out ? '0 : mem_rdata;
        rr_ptr   <= (32'(owner) == NR - 1) ? '0 : owner + 1'b1;
      end
      if (state == IDLE && any_pending) begin
        owner     <= pick;
        mem_rw    <= slot_rw[pick];
        mem_addr  <= slot_addr[pick];
        mem_wdata <= slot_data[pick];
      end
      if (|dup)
        err_overflow <= 1'b1;
    end
  end

  // Slot payload storage; written only when the slot accepts a request.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NR; i++) begin
      if (capture[i]) begin
        slot_rw[i]   <= req_rw[i];
        slot_addr[i] <= req_addr[i*AW +: AW];
        slot_data[i] <= req_data[i*DW +: DW];
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_rw;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic            mem_valid, mem_rw;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ready;
  logic [DW-1:0]   mem_rdata;
  logic            busy;
  logic [0:0]      owner;
  logic            err_overflow;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .TIMEOUT_CYC(256)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rw(req_rw),
    .req_addr(req_addr), .req_data(req_data), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .mem_valid(mem_valid), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner), .err_overflow(err_overflow)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // age: -1 = no transaction in flight, 0 = the mem_valid cycle, >=1 = waiting.
  bit            model_on = 1'b0;
  logic [N-1:0]  m_pend, m_prev, e_rsp;
  logic          m_rw   [N];
  logic [AW-1:0] m_addr [N];
  logic [DW-1:0] m_data [N];
  int            age, m_owner, m_rr;
  logic          e_rw, e_ovf;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rsp_data;

  task automatic model_step();
    bit  done, busy_pre;
    int  owner_pre, best, bestd, d;
    if (!rst) begin
      model_on = 1'b1;
      m_pend = '0; m_prev = '0; e_rsp = '0;
      age = -1; m_owner = 0; m_rr = 0;
      e_rw = 1'b0; e_addr = '0; e_wdata = '0; e_rsp_data = '0; e_ovf = 1'b0;
      return;
    end
    if (!model_on) return;
    busy_pre  = (age >= 0);
    owner_pre = m_owner;
    done      = (age >= 1) && mem_ready;
    e_rsp     = '0;
    if (done) begin
      e_rsp[m_owner] = 1'b1;
      e_rsp_data     = mem_rdata;
    end
    if (age < 0) begin
      best = -1; bestd = N;
      for (int i = 0; i < N; i++) begin
        d = (i - m_rr + N) % N;
        if (m_pend[i] && d < bestd) begin bestd = d; best = i; end
      end
      if (best >= 0) begin
        m_owner = best; e_rw = m_rw[best]; e_addr = m_addr[best];
        e_wdata = m_data[best]; age = 0;
      end
    end else if (done) begin
      m_pend[m_owner] = 1'b0;
      m_rr = (m_owner + 1) % N;
      age  = -1;
    end else begin
      age++;
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && !m_pend[i]) begin
        m_pend[i] = 1'b1;
        m_rw[i]   = req_rw[i];
        m_addr[i] = req_addr[i*AW +: AW];
        m_data[i] = req_data[i*DW +: DW];
      end else if (req_valid[i] && !m_prev[i] && !(busy_pre && owner_pre == i)) begin
        e_ovf = 1'b1;
      end
    end
    m_prev = req_valid;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (model_on) begin
      chk("mem_valid", DW'(mem_valid), DW'(age == 0));
      chk("busy", DW'(busy), DW'(age >= 0));
      chk("owner", DW'(owner), DW'(m_owner));
      chk("mem_rw", DW'(mem_rw), DW'(e_rw));
      chk("mem_addr", DW'(mem_addr), DW'(e_addr));
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("rsp_ready", DW'(rsp_ready), DW'(e_rsp));
      chk("err_overflow", DW'(err_overflow), DW'(e_ovf));
      if (e_rsp != '0) chk("rsp_data", rsp_data, e_rsp_data);
    end
  end

  // ---------------- event monitor ----------------
  typedef struct { int cyc; logic rw; logic [AW-1:0] addr; logic [DW-1:0] wdata; } mev_t;
  typedef struct { int cyc; logic [N-1:0] vec; logic [DW-1:0] data; } rev_t;
  mev_t mq[$];
  rev_t rq[$];
  int   cyc = 0;

  initial forever begin
    @(posedge clk); #1;
    cyc++;
    if (mem_valid) mq.push_back('{cyc, mem_rw, mem_addr, mem_wdata});
    if (rsp_ready != '0) rq.push_back('{cyc, rsp_ready, rsp_data});
  end

  // ---------------- memory responder ----------------
  // mem_lat > 0: ready that many cycles after mem_valid; < 0: never; 0: random 1..5.
  int            mem_lat = 1;
  bit            noise = 1'b0, fix = 1'b0, kick = 1'b0;
  logic [DW-1:0] fixv = '0;

  initial begin
    bit armed, hit;
    int cnt;
    armed = 1'b0; cnt = 0;
    mem_ready = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      hit = 1'b0;
      if (armed) begin
        cnt--;
        if (cnt <= 0) begin hit = 1'b1; armed = 1'b0; end
      end
      if (mem_valid && mem_lat >= 0) begin
        armed = 1'b1;
        cnt   = (mem_lat == 0) ? int'($urandom_range(1, 5)) : mem_lat;
      end
      mem_ready = hit | kick | (noise && $urandom_range(0, 15) == 0);
      mem_rdata = fix ? fixv : {$urandom(), $urandom(), $urandom(), $urandom()};
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_req(input int i, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_rw[i]             = rw;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
    req_valid[i]          = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    mq.delete();
    rq.delete();
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int c = 0; c < budget && rq.size() < n; c++) step();
    chk("rsp_count", DW'(rq.size()), DW'(n));
  endtask

  int t0;

  initial begin
    rst = 1'b0; req_valid = '0; req_rw = '0; req_addr = '0; req_data = '0;
    step(); step();
    // Reset state.
    chk("rst_busy", DW'(busy), DW'(1'b0));
    chk("rst_mem_valid", DW'(mem_valid), DW'(1'b0));
    chk("rst_rsp_ready", DW'(rsp_ready), DW'(2'b00));
    chk("rst_owner", DW'(owner), DW'(1'b0));
    chk("rst_overflow", DW'(err_overflow), DW'(1'b0));
    chk("rst_mem_addr", DW'(mem_addr), DW'(32'h0));
    rst = 1'b1;

    // Single read with 3-cycle memory latency.
    mem_lat = 3; fix = 1'b1; fixv = {16{8'hA5}};
    t0 = cyc;
    drive_req(0, 1'b0, 32'h0000_1230, '0);
    step(); req_valid = '0;
    wait_rsp(1, 40);
    chk("t1_mem_count", DW'(mq.size()), DW'(1));
    if (mq.size() > 0 && rq.size() > 0) begin
      chk("t1_addr", DW'(mq[0].addr), DW'(32'h0000_1230));
      chk("t1_rw", DW'(mq[0].rw), DW'(1'b0));
      chk("t1_issue_lat", DW'(mq[0].cyc - t0), DW'(2));
      chk("t1_rsp_vec", DW'(rq[0].vec), DW'(2'b01));
      chk("t1_rsp_data", rq[0].data, {16{8'hA5}});
      chk("t1_rsp_lat", DW'(rq[0].cyc - mq[0].cyc), DW'(4));
    end
    fix = 1'b0;

    // Simultaneous requests, immediate memory ready.
    do_reset();
    mem_lat = 1;
    drive_req(0, 1'b0, 32'h100, '0);
    drive_req(1, 1'b0, 32'h200, '0);
    step(); req_valid = '0;
    wait_rsp(2, 60);
    if (mq.size() >= 2 && rq.size() >= 2) begin
      chk("t2_first_addr", DW'(mq[0].addr), DW'(32'h100));
      chk("t2_second_addr", DW'(mq[1].addr), DW'(32'h200));
      chk("t2_b2b_gap", DW'(mq[1].cyc - mq[0].cyc), DW'(3));
      chk("t2_rsp0", DW'(rq[0].vec), DW'(2'b01));
      chk("t2_rsp1", DW'(rq[1].vec), DW'(2'b10));
    end
    drive_req(0, 1'b0, 32'h100, '0);
    drive_req(1, 1'b0, 32'h200, '0);
    step(); req_valid = '0;
    wait_rsp(3, 60);
    if (mq.size() >= 3) chk("t2_rr_wrap", DW'(mq[2].addr), DW'(32'h100));

    // Fairness: both requesters keep asking.
    do_reset();
    mem_lat = 2;
    drive_req(0, 1'b0, 32'h400, '0);
    drive_req(1, 1'b0, 32'h500, '0);
    wait_rsp(4, 100);
    req_valid = '0;
    for (int k = 0; k < 4 && k < mq.size(); k++)
      chk("t3_alternate", DW'(mq[k].addr), (k % 2 == 0) ? DW'(32'h400) : DW'(32'h500));

    // Write-back.
    do_reset();
    drive_req(1, 1'b1, 32'h3F0, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
    step(); req_valid = '0;
    wait_rsp(1, 40);
    if (mq.size() > 0 && rq.size() > 0) begin
      chk("t4_rw", DW'(mq[0].rw), DW'(1'b1));
      chk("t4_addr", DW'(mq[0].addr), DW'(32'h3F0));
      chk("t4_wdata", mq[0].wdata, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
      chk("t4_rsp_vec", DW'(rq[0].vec), DW'(2'b10));
    end

    // Overflow: second pulse on slot 1 while it waits behind requester 0.
    do_reset();
    mem_lat = 6;
    drive_req(0, 1'b0, 32'h10, '0);
    step(); req_valid = '0;
    drive_req(1, 1'b0, 32'h20, '0);
    step(); req_valid = '0;
    step();
    drive_req(1, 1'b0, 32'h30, '0);
    step(); req_valid = '0;
    step();
    chk("t5_overflow", DW'(err_overflow), DW'(1'b1));
    wait_rsp(2, 80);
    repeat (8) step();
    chk("t5_mem_count", DW'(mq.size()), DW'(2));
    if (mq.size() >= 2) chk("t5_kept_addr", DW'(mq[1].addr), DW'(32'h20));

    // Reset during WAIT, then a late mem_ready.
    do_reset();
    mem_lat = -1;
    drive_req(0, 1'b0, 32'h50, '0);
    step(); req_valid = '0;
    repeat (3) step();
    chk("t6_busy_before", DW'(busy), DW'(1'b1));
    rst = 1'b0;
    step();
    chk("t6_busy", DW'(busy), DW'(1'b0));
    chk("t6_mem_valid", DW'(mem_valid), DW'(1'b0));
    chk("t6_owner", DW'(owner), DW'(1'b0));
    chk("t6_mem_addr", DW'(mem_addr), DW'(32'h0));
    chk("t6_mem_rw", DW'(mem_rw), DW'(1'b0));
    chk("t6_mem_wdata", mem_wdata, '0);
    chk("t6_rsp_ready", DW'(rsp_ready), DW'(2'b00));
    chk("t6_rsp_data", rsp_data, '0);
    rst = 1'b1;
    rq.delete();
    kick = 1'b1;
    step();
    kick = 1'b0;
    repeat (6) step();
    chk("t6_no_rsp", DW'(rq.size()), DW'(0));
    chk("t6_idle", DW'(busy), DW'(1'b0));

    // Randomized traffic with spurious mem_ready and occasional resets.
    do_reset();
    mem_lat = 0; noise = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0)
          drive_req(i, 1'($urandom_range(0, 1)), $urandom(),
                    {$urandom(), $urandom(), $urandom(), $urandom()});
        else
          req_valid[i] = 1'b0;
      end
      rst = ($urandom_range(0, 399) != 0);
      step();
    end
    req_valid = '0; rst = 1'b1; noise = 1'b0;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
